lsu_bus_master: RTL and testbench

//  CPU-side initiator for memory-stage loads/stores over a valid/ready word bus.
//  - Turns MemRead/MemWrite/MemLen/addr into bus requests with byte enables and lane-shifted write data.
//  - Stalls the pipeline until the response returns, then aligns and zero/sign-extends load data.
//  - Sits between the MEM stage and an external data memory or interconnect.

---
 rtl/lsu_bus_master.sv | 195 +++++++++++++++++++
 tb/tb_lsu_bus_master.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_master.sv
// ============================================================================
// Module   : lsu_bus_master
// Brief    : MEM-stage load/store initiator on a valid/ready word bus with
//            byte enables, lane shifting and load alignment/extension.
//            Optional LSU_MISALIGN_SPLIT_EN splits word-crossing accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_bus_master #(
  parameter int WIDTH = 32,
  parameter int AW    = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CE,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [2:0]       MemLen,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             stall,
  output logic             done,
  output logic             misalign,
  output logic             bus_req_valid,
  input  logic             bus_req_ready,
  output logic             bus_we,
  output logic [AW-1:0]    bus_addr,
  output logic [3:0]       bus_byteen,
  output logic [WIDTH-1:0] bus_wdata,
  input  logic             bus_rsp_valid,
  input  logic [WIDTH-1:0] bus_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RSP  = 3'd2,
`ifdef LSU_MISALIGN_SPLIT_EN
    S_REQ2 = 3'd3,
    S_RSP2 = 3'd4,
`endif
    S_DONE = 3'd5
  } state_t;

  state_t           r_state;
  logic [1:0]       r_off;
  logic [2:0]       r_len;

  logic             w_req;
  logic [1:0]       w_off;
  logic             w_is_byte;
  logic             w_is_half;
  logic [7:0]       w_be8;
  logic [WIDTH-1:0] w_in_m;
  logic             w_misal;

  assign w_req     = (MemRead | MemWrite) & CE;
  assign w_off     = addr[1:0];
  assign w_is_byte = (MemLen[1:0] == 2'b01);
  assign w_is_half = (MemLen[1:0] == 2'b10);
  // Two-word lane map: bits [7:4] are lanes that spill into the next word.
  assign w_be8     = (w_is_byte ? 8'h01 : (w_is_half ? 8'h03 : 8'h0F)) << w_off;
  assign w_in_m    = in & (w_is_byte ? {{(WIDTH-8){1'b0}}, 8'hFF} :
                           w_is_half ? {{(WIDTH-16){1'b0}}, 16'hFFFF} :
                                       {WIDTH{1'b1}});

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [2*WIDTH-1:0] w_wdata_x;
  logic               w_split;
  logic               r_split;
  logic [3:0]         r_be_hi;
  logic [WIDTH-1:0]   r_wdata_hi;
  logic [WIDTH-1:0]   r_rdata_lo;
  assign w_wdata_x = {{WIDTH{1'b0}}, w_in_m} << {w_off, 3'b000};
  assign w_split   = |w_be8[7:4];
  assign w_misal   = 1'b0;
`else
  logic [WIDTH-1:0] w_wdata_x;
  assign w_wdata_x = w_in_m << {w_off, 3'b000};
  assign w_misal   = (|w_be8[7:4]) | (w_is_half & w_off[0]);
`endif

  assign stall = ((r_state == S_IDLE) && w_req) ||
                 ((r_state != S_IDLE) && (r_state != S_DONE));

  // d holds {beat2, beat1}; the result is the addressed bytes, extended.
  function automatic logic [WIDTH-1:0] f_extract(input logic [2*WIDTH-1:0] d,
                                                 input logic [1:0]         off,
                                                 input logic [2:0]         len);
    logic [WIDTH-1:0] s;
    s = WIDTH'(d >> {off, 3'b000});
    case (len[1:0])
      2'b01:   f_extract = {{(WIDTH-8){len[2] & s[7]}}, s[7:0]};
      2'b10:   f_extract = {{(WIDTH-16){len[2] & s[15]}}, s[15:0]};
      default: f_extract = s;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_off         <= 2'b00;
      r_len         <= 3'b000;
      out           <= '0;
      done          <= 1'b0;
      misalign      <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_byteen    <= 4'b0000;
      bus_wdata     <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_split       <= 1'b0;
      r_be_hi       <= 4'b0000;
      r_wdata_hi    <= '0;
      r_rdata_lo    <= '0;
`endif
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_off <= w_off;
            r_len <= MemLen;
            if (w_misal) begin
              r_state  <= S_DONE;
              done     <= 1'b1;
              misalign <= 1'b1;
            end else begin
              r_state       <= S_REQ;
              bus_req_valid <= 1'b1;
              bus_we        <= MemWrite;
              bus_addr      <= addr[AW+1:2];
              bus_byteen    <= w_be8[3:0];
              bus_wdata     <= w_wdata_x[WIDTH-1:0];
`ifdef LSU_MISALIGN_SPLIT_EN
              r_split       <= w_split;
              r_be_hi       <= w_be8[7:4];
              r_wdata_hi    <= w_wdata_x[2*WIDTH-1:WIDTH];
`endif
            end
          end
        end
        S_REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            r_state       <= S_RSP;
          end
        end
        S_RSP: begin
          if (bus_rsp_valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            if (r_split) begin
              r_rdata_lo    <= bus_rdata;
              r_state       <= S_REQ2;
              bus_req_valid <= 1'b1;
              bus_addr      <= bus_addr + {{(AW-1){1'b0}}, 1'b1};
              bus_byteen    <= r_be_hi;
              bus_wdata     <= r_wdata_hi;
            end else
`endif
            begin
              if (!bus_we) out <= f_extract({{WIDTH{1'b0}}, bus_rdata}, r_off, r_len);
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        S_REQ2: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            r_state       <= S_RSP2;
          end
        end
        S_RSP2: begin
          if (bus_rsp_valid) begin
            if (!bus_we) out <= f_extract({bus_rdata, r_rdata_lo}, r_off, r_len);
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
`endif
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_master.sv
// ============================================================================
// Module   : tb_lsu_bus_master
// Brief    : Directed bench for lsu_bus_master (follows LSU_MISALIGN_SPLIT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        CE;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  MemLen;
  logic [31:0] addr;
  logic [31:0] in;
  logic [31:0] out;
  logic        stall;
  logic        done;
  logic        misalign;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu_bus_master #(.WIDTH(32), .AW(30)) dut (
    .clk           (clk),
    .rst           (rst),
    .CE            (CE),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .MemLen        (MemLen),
    .addr          (addr),
    .in            (in),
    .out           (out),
    .stall         (stall),
    .done          (done),
    .misalign      (misalign),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_byteen    (bus_byteen),
    .bus_wdata     (bus_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rdata     (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete single-beat access; request held through DONE like a stalled pipe.
  task automatic access(input string tag, input logic we, input logic [2:0] len,
                        input logic [31:0] a, input logic [31:0] wd, input int rdy_wait,
                        input logic [31:0] rd, input logic [3:0] exp_be,
                        input logic [29:0] exp_addr, input logic [31:0] exp_wd,
                        input logic [31:0] exp_out);
    CE = 1'b1; MemRead = ~we; MemWrite = we; MemLen = len; addr = a; in = wd;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    #1;
    chk({tag, " idle stall"}, {31'b0, stall}, 32'd1);
    chk({tag, " idle valid"}, {31'b0, bus_req_valid}, 32'd0);
    tick();
    for (int k = 0; k <= rdy_wait; k++) begin
      bus_req_ready = (k == rdy_wait);
      #1;
      chk({tag, " req valid"}, {31'b0, bus_req_valid}, 32'd1);
      chk({tag, " req addr"}, {2'b0, bus_addr}, {2'b0, exp_addr});
      chk({tag, " req byteen"}, {28'b0, bus_byteen}, {28'b0, exp_be});
      chk({tag, " req we"}, {31'b0, bus_we}, {31'b0, we});
      if (we) chk({tag, " req wdata"}, bus_wdata, exp_wd);
      chk({tag, " req stall"}, {31'b0, stall}, 32'd1);
      tick();
    end
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b1; bus_rdata = rd;
    #1;
    chk({tag, " rsp stall"}, {31'b0, stall}, 32'd1);
    chk({tag, " rsp valid"}, {31'b0, bus_req_valid}, 32'd0);
    tick();
    bus_rsp_valid = 1'b0;
    #1;
    chk({tag, " done"}, {31'b0, done}, 32'd1);
    chk({tag, " done stall"}, {31'b0, stall}, 32'd0);
    chk({tag, " out"}, out, exp_out);
    tick();
    MemRead = 1'b0; MemWrite = 1'b0;
    #1;
    chk({tag, " done drop"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; CE = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemLen = 3'b000;
    addr = '0; in = '0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst out", out, 32'h0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst misalign", {31'b0, misalign}, 32'd0);
    chk("rst valid", {31'b0, bus_req_valid}, 32'd0);
    chk("rst we", {31'b0, bus_we}, 32'd0);
    chk("rst byteen", {28'b0, bus_byteen}, 32'd0);
    chk("rst stall", {31'b0, stall}, 32'd0);

    // Word / byte loads and a half store with a slow ready
    access("t1 lw", 1'b0, 3'b000, 32'h40, 32'h0, 0, 32'hDEADBEEF, 4'b1111, 30'h10, 32'h0, 32'hDEADBEEF);
    access("t2 lb", 1'b0, 3'b101, 32'h43, 32'h0, 0, 32'h80123456, 4'b1000, 30'h10, 32'h0, 32'hFFFFFF80);
    access("t2 lbu", 1'b0, 3'b001, 32'h43, 32'h0, 0, 32'h80123456, 4'b1000, 30'h10, 32'h0, 32'h00000080);
    access("t3 sh", 1'b1, 3'b010, 32'h22, 32'h0000ABCD, 3, 32'h0, 4'b1100, 30'h08, 32'hABCD0000, 32'h00000080);

`ifdef LSU_MISALIGN_SPLIT_EN
    // Word at 0x41 crosses into word 0x11
    CE = 1'b1; MemRead = 1'b1; MemLen = 3'b000; addr = 32'h41; bus_req_ready = 1'b1;
    tick();
    chk("t4 b1 valid", {31'b0, bus_req_valid}, 32'd1);
    chk("t4 b1 addr", {2'b0, bus_addr}, 32'h10);
    chk("t4 b1 byteen", {28'b0, bus_byteen}, 32'b1110);
    tick();
    bus_rsp_valid = 1'b1; bus_rdata = 32'h11223344;
    tick();
    bus_rsp_valid = 1'b0;
    #1;
    chk("t4 b2 valid", {31'b0, bus_req_valid}, 32'd1);
    chk("t4 b2 addr", {2'b0, bus_addr}, 32'h11);
    chk("t4 b2 byteen", {28'b0, bus_byteen}, 32'b0001);
    chk("t4 b2 stall", {31'b0, stall}, 32'd1);
    tick();
    bus_rsp_valid = 1'b1; bus_rdata = 32'h55667788;
    tick();
    bus_rsp_valid = 1'b0; bus_req_ready = 1'b0;
    #1;
    chk("t4 done", {31'b0, done}, 32'd1);
    chk("t4 misalign", {31'b0, misalign}, 32'd0);
    chk("t4 out", out, 32'h88112233);
    tick();
    MemRead = 1'b0;
    access("t4 lhu o1", 1'b0, 3'b010, 32'h21, 32'h0, 0, 32'h00ABCD00, 4'b0110, 30'h08, 32'h0, 32'h0000ABCD);
`else
    // Rejected accesses: misalign pulse, no bus traffic, out kept
    CE = 1'b1; MemRead = 1'b1; MemLen = 3'b000; addr = 32'h41; bus_req_ready = 1'b1;
    #1;
    chk("t4 idle stall", {31'b0, stall}, 32'd1);
    tick();
    chk("t4 misalign", {31'b0, misalign}, 32'd1);
    chk("t4 done", {31'b0, done}, 32'd1);
    chk("t4 valid", {31'b0, bus_req_valid}, 32'd0);
    chk("t4 stall", {31'b0, stall}, 32'd0);
    chk("t4 out", out, 32'h00000080);
    tick();
    MemLen = 3'b010; addr = 32'h21;
    #1;
    chk("t4 mis drop", {31'b0, misalign}, 32'd0);
    tick();
    chk("t4 half misalign", {31'b0, misalign}, 32'd1);
    chk("t4 half valid", {31'b0, bus_req_valid}, 32'd0);
    tick();
    MemRead = 1'b0; bus_req_ready = 1'b0;
`endif

    // Reset while waiting for the response
    CE = 1'b1; MemRead = 1'b1; MemLen = 3'b000; addr = 32'h40; bus_req_ready = 1'b1;
    tick();
    tick();
    bus_req_ready = 1'b0; rst = 1'b1; MemRead = 1'b0;
    #1;
    chk("t5 in rsp stall", {31'b0, stall}, 32'd1);
    tick();
    rst = 1'b0;
    bus_rsp_valid = 1'b1; bus_rdata = 32'h12345678;
    #1;
    chk("t5 rst out", out, 32'h0);
    chk("t5 rst valid", {31'b0, bus_req_valid}, 32'd0);
    chk("t5 rst byteen", {28'b0, bus_byteen}, 32'd0);
    chk("t5 rst stall", {31'b0, stall}, 32'd0);
    tick();
    bus_rsp_valid = 1'b0;
    #1;
    chk("t5 late done", {31'b0, done}, 32'd0);
    chk("t5 late out", out, 32'h0);
    tick();

    // CE gating in IDLE, then CE dropped mid-access
    CE = 1'b0; MemRead = 1'b1; MemLen = 3'b000; addr = 32'h40; bus_req_ready = 1'b1;
    #1;
    chk("t6 ce0 stall", {31'b0, stall}, 32'd0);
    tick();
    chk("t6 ce0 valid", {31'b0, bus_req_valid}, 32'd0);
    CE = 1'b1;
    tick();
    CE = 1'b0;
    #1;
    chk("t6 req valid", {31'b0, bus_req_valid}, 32'd1);
    tick();
    bus_rsp_valid = 1'b1; bus_rdata = 32'hCAFEF00D;
    #1;
    chk("t6 rsp stall", {31'b0, stall}, 32'd1);
    tick();
    bus_rsp_valid = 1'b0; MemRead = 1'b0; bus_req_ready = 1'b0;
    #1;
    chk("t6 done", {31'b0, done}, 32'd1);
    chk("t6 out", out, 32'hCAFEF00D);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
